// File: rtl/seq_gen_if.sv
// seq_gen_if: bundles the frame request inputs and the serial output /
// status signals of seq_gen. The generator connects through the slave
// modport; whatever drives frame requests uses the master modport.
interface seq_gen_if;
   logic       start;
   logic [7:0] data;
   logic       dout;
   logic       busy;
   logic       done;
   logic [7:0] frame_cnt;

   modport master (
      output start,
      output data,
      input  dout,
      input  busy,
      input  done,
      input  frame_cnt
   );

   modport slave (
      input  start,
      input  data,
      output dout,
      output busy,
      output done,
      output frame_cnt
   );
endinterface

// File: rtl/seq_gen.sv
// seq_gen: serial frame generator.
// A frame is the PATTERN sync byte (MSB first), then the payload byte
// captured on the accepting edge (MSB first), then optionally one even
// parity bit, then a one-cycle DONE slot that pulses done and bumps
// frame_cnt. dout is a register, so the first sync bit appears in the
// cycle right after start is accepted.
// Optional feature macro: SEQ_GEN_PARITY_EN (adds the PAR state and the
// even parity bit; without it frames are 16 bits long).
module seq_gen #(
   parameter logic [7:0] PATTERN  = 8'b0101_0101,
   parameter logic       IDLE_LVL = 1'b1
) (
   input  logic     clk,
   input  logic     rst,
   seq_gen_if.slave bus
);

   typedef enum logic [4:0] {
      S_IDLE = 5'b00001,
      S_SYNC = 5'b00010,
      S_DATA = 5'b00100,
      S_PAR  = 5'b01000,
      S_DONE = 5'b10000
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_next;
   logic [7:0] r_shift;
   logic [7:0] w_shift_next;
   logic       r_dout;
   logic       w_dout_next;
   logic [7:0] r_frame_cnt;
   logic       w_frame_inc;
`ifdef SEQ_GEN_PARITY_EN
   logic       r_par;
   logic       w_par_next;
`endif

   // State register plus the per-frame working registers (bit counter,
   // payload shift register and the registered serial output).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
         r_shift <= 8'd0;
         r_dout  <= IDLE_LVL;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_shift <= w_shift_next;
         r_dout  <= w_dout_next;
      end
   end

`ifdef SEQ_GEN_PARITY_EN
   // Parity of the payload, computed once when the byte is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_par <= 1'b0;
      end else begin
         r_par <= w_par_next;
      end
   end
`endif

   // Completed-frame counter; free-running wrap at 255 -> 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= 8'd0;
      end else if (w_frame_inc) begin
         r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

   // Next-state logic. dout is computed for the state being entered so
   // that the registered output lines up with the state it belongs to.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_shift_next = r_shift;
      w_dout_next  = IDLE_LVL;
      w_frame_inc  = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      w_par_next   = r_par;
`endif
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_next = S_SYNC;
               w_cnt_next   = 3'd0;
               w_shift_next = bus.data;
               w_dout_next  = PATTERN[7];
`ifdef SEQ_GEN_PARITY_EN
               w_par_next   = ^bus.data;
`endif
            end
         end
         S_SYNC: begin
            w_cnt_next = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
               // Last sync bit on the line: next cycle carries payload MSB.
               w_state_next = S_DATA;
               w_dout_next  = r_shift[7];
               w_shift_next = {r_shift[6:0], 1'b0};
            end else begin
               // r_cnt+1 sync bits will have been sent; index 6-r_cnt is next.
               w_dout_next = PATTERN[3'd6 - r_cnt];
            end
         end
         S_DATA: begin
            w_cnt_next = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
`ifdef SEQ_GEN_PARITY_EN
               w_state_next = S_PAR;
               w_dout_next  = r_par;
`else
               w_state_next = S_DONE;
               w_dout_next  = IDLE_LVL;
               w_frame_inc  = 1'b1;
`endif
            end else begin
               w_dout_next  = r_shift[7];
               w_shift_next = {r_shift[6:0], 1'b0};
            end
         end
`ifdef SEQ_GEN_PARITY_EN
         S_PAR: begin
            w_state_next = S_DONE;
            w_dout_next  = IDLE_LVL;
            w_frame_inc  = 1'b1;
         end
`endif
         S_DONE: begin
            // start is deliberately not looked at here; it is dropped.
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign bus.dout      = r_dout;
   assign bus.busy      = (r_state == S_SYNC) || (r_state == S_DATA) || (r_state == S_PAR);
   assign bus.done      = (r_state == S_DONE);
   assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter PATTERN, default 8'b0101_0101, the sync word sent MSB first ahead of every payload.
REQ-002 SHALL have parameter IDLE_LVL, default 1'b1, the dout line level when no frame is in flight.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-006 SHALL have port data  input  8  payload byte, captured on the accepting edge.
REQ-007 SHALL have port dout  output  1  registered serial bitstream.
REQ-008 SHALL have port busy  output  1  high while a frame is on dout.
REQ-009 SHALL have port done  output  1  one-cycle pulse after a frame's last bit.
REQ-010 SHALL have port frame_cnt  output  8  count of completed frames.

Function
REQ-011 SHALL implement the states IDLE, SYNC, DATA, PAR and DONE, with one-hot encoding and a default branch to IDLE.
REQ-012 SHALL, in IDLE with start=1 at an edge, latch data into an 8-bit shift register, clear the bit counter and enter SYNC.
REQ-013 SHALL drive dout=PATTERN[7] in the first cycle after the accepting edge, which gives a start-to-first-bit latency of 1 cycle.
REQ-014 SHALL, in SYNC, output PATTERN[7] down to PATTERN[0] on 8 consecutive cycles, then enter DATA.
REQ-015 SHALL, in DATA, output the latched byte MSB first on 8 consecutive cycles, then enter PAR (parity enabled) or DONE (parity disabled).
REQ-016 SHALL, in PAR, output one parity bit for 1 cycle, then enter DONE.
REQ-017 SHALL, in DONE, drive dout=IDLE_LVL, busy=0 and done=1 for exactly 1 cycle, increment frame_cnt, then enter IDLE.
REQ-018 SHALL hold busy=1 for every cycle in which dout carries a frame bit (SYNC, DATA, PAR) and busy=0 otherwise.
REQ-019 SHALL ignore start in every state except IDLE, so start asserted during a frame or during DONE is dropped rather than queued.
REQ-020 SHALL keep the latched byte unaffected by changes on data after the accepting edge.
REQ-021 SHALL use a 3-bit bit counter that wraps 7->0 at each SYNC/DATA boundary.
REQ-022 SHALL wrap frame_cnt from 255 to 0 without saturating.
REQ-023 SHALL support back-to-back frames with a minimum of 1 IDLE cycle between DONE and the next accepted start.

Reset
REQ-024 SHALL, while rst=1 and independent of clk, force state=IDLE, dout=IDLE_LVL, busy=0, done=0, frame_cnt=0, and clear the bit counter and shift register.
REQ-025 SHALL, on reset asserted mid-frame, abort the frame immediately with no done pulse and no frame_cnt increment.
REQ-026 SHALL accept start no earlier than the first rising clk edge after rst deasserts.

Configuration
REQ-027 SHALL include the PAR state and even parity only when macro SEQ_GEN_PARITY_EN is defined.
REQ-028 SHALL, with SEQ_GEN_PARITY_EN defined, produce a 17-bit frame whose parity bit is the XOR of the 8 payload bits, i.e. an even count of ones across payload plus parity.
REQ-029 SHALL, without SEQ_GEN_PARITY_EN, produce a 16-bit frame, synthesize no PAR state logic, and keep all other timing unchanged.

Verification
REQ-030 SHALL cover: reset released, start=1 with data=8'hA5, parity disabled -> dout=0,1,0,1,0,1,0,1 then 1,0,1,0,0,1,0,1; busy high for 16 cycles; done pulse on cycle 17; frame_cnt=1.
REQ-031 SHALL cover: same stimulus with SEQ_GEN_PARITY_EN defined -> parity bit 0 on cycle 17, done on cycle 18; data=8'h07 -> parity bit 1.
REQ-032 SHALL cover: start pulsed at bit 5 of SYNC and again during DONE -> both ignored, exactly one frame, frame_cnt increments by 1.
REQ-033 SHALL cover: rst pulsed during DATA bit 3 -> dout=1, busy=0 and frame_cnt=0 immediately; next start sends a complete fresh frame.
REQ-034 SHALL cover: 256 back-to-back frames -> frame_cnt reads 0 after the 256th done.
REQ-035 SHALL cover: dout looped into the existing 01010101 Mealy detector (din=dout) -> its flag asserts once, on the edge sampling the 8th sync bit, for payload 8'h00.
